// File: rtl/down_counter_timer_pkg.sv
// rtl/down_counter_timer_pkg.sv - shared constants for the down counter/timer
//
// Purpose:
//   Holds the FSM state encoding and the default counter width. The timer
//   top and its count register both import this package.
//
// Contents:
//   DEFAULT_WIDTH  default counter/load width (legal 2..16)
//   ST_IDLE        never loaded, or loaded with zero
//   ST_RUN         counting down
//   ST_DONE        one-shot run has expired
//   is_run         helper that decodes the RUN state
package down_counter_timer_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // Plain 2-bit constants so the encoding stays fixed for netlists and
  // tooling that expect these exact codes.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  function automatic logic is_run(input logic [1:0] st);
    return (st == ST_RUN);
  endfunction

endpackage

// File: rtl/down_counter_timer_down_count_reg.sv
// rtl/down_counter_timer_down_count_reg.sv - count and reload registers for the timer
//
// Purpose:
//   WIDTH-bit count register plus the reload register that remembers the
//   last loaded value. The FSM in the top decides which operation applies
//   on each edge; this block only executes it.
//
// Ports:
//   clock         system clock, all updates on posedge
//   reset         synchronous active-high reset, clears count and reload_reg
//   load          load load_value into count and reload_reg
//   load_value    value to load
//   reload        copy reload_reg into count (periodic expiry)
//   clear         force count to zero (one-shot expiry)
//   decrement     count <= count - 1 (never applied at zero)
//   count         current count, registered
//   count_is_one  combinational, count == 1
module down_count_reg
  import down_counter_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             reload,
  input  logic             clear,
  input  logic             decrement,
  output logic [WIDTH-1:0] count,
  output logic             count_is_one
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] reload_reg;
  logic             count_is_zero;

  assign count_is_one  = (count == ONE);
  assign count_is_zero = (count == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      count      <= '0;
      reload_reg <= '0;
    end else if (load) begin
      count      <= load_value;
      reload_reg <= load_value;
    end else if (reload) begin
      count <= reload_reg;
    end else if (clear) begin
      count <= '0;
    end else if (decrement && !count_is_zero) begin
      // The zero guard keeps the counter from wrapping to all-ones even if
      // the controller ever asks for a decrement it should not.
      count <= count - ONE;
    end
  end

endmodule

// File: rtl/down_counter_timer.sv
// rtl/down_counter_timer.sv - programmable down counter/timer with one-shot and periodic modes
//
// Purpose:
//   Counts down from a loaded value while enable is high and emits a
//   one-cycle terminal-count pulse on the edge the count leaves 1. In
//   periodic mode the count restarts from the last loaded value, giving a
//   divider whose period is exactly that value in enabled cycles.
//
// Ports:
//   clock        system clock, all state updates on posedge
//   reset        synchronous active-high reset
//   load         load load_value into count and reload register (any state)
//   load_value   start/reload value
//   enable       decrement qualifier; count holds when low
//   auto_reload  1 = periodic, 0 = one-shot; sampled at the expiry edge
//   count        current count, registered
//   zero         combinational, count == 0
//   tc_pulse     registered terminal-count pulse, one cycle wide
//   running      registered, high while the FSM is in RUN
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             tc_pulse,
  output logic             running
);

  logic [1:0] state;
  logic [1:0] state_next;
  logic       count_is_one;
  logic       in_run;
  logic       expire;
  logic       do_reload;
  logic       do_clear;
  logic       do_decrement;

  assign in_run = is_run(state);

  // Expiry only happens without a competing load; load wins the edge and
  // suppresses the pulse.
  assign expire       = in_run && enable && count_is_one && !load;
  assign do_reload    = expire && auto_reload;
  assign do_clear     = expire && !auto_reload;
  assign do_decrement = in_run && enable && !count_is_one && !load;

  always_comb begin
    state_next = state;
    if (load) begin
      state_next = (load_value != '0) ? ST_RUN : ST_IDLE;
    end else if (do_clear) begin
      state_next = ST_DONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      tc_pulse <= 1'b0;
      running  <= 1'b0;
    end else begin
      state    <= state_next;
      tc_pulse <= expire;
      // running is registered next to state so it never glitches.
      running  <= is_run(state_next);
    end
  end

  down_count_reg #(
    .WIDTH(WIDTH)
  ) u_count_reg (
    .clock       (clock),
    .reset       (reset),
    .load        (load),
    .load_value  (load_value),
    .reload      (do_reload),
    .clear       (do_clear),
    .decrement   (do_decrement),
    .count       (count),
    .count_is_one(count_is_one)
  );

  assign zero = (count == '0);

endmodule

// File: tb/tb_down_counter_timer.sv
// tb/tb_down_counter_timer.sv - scoreboard bench for down_counter_timer
module tb_down_counter_timer;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] count;
    logic         zero;
    logic         tc;
    logic         running;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic         enable = 1'b0;
  logic         auto_reload = 1'b0;
  logic [W-1:0] count;
  logic         zero;
  logic         tc_pulse;
  logic         running;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [W-1:0] m_count = '0;
  logic [W-1:0] m_reload = '0;
  int           m_state = 0;  // 0 idle, 1 run, 2 done
  logic         m_tc = 1'b0;

  exp_t sb[$];

  always #5 clock = ~clock;

  down_counter_timer #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .enable     (enable),
    .auto_reload(auto_reload),
    .count      (count),
    .zero       (zero),
    .tc_pulse   (tc_pulse),
    .running    (running)
  );

  task automatic model(input logic rst, input logic ld, input logic [W-1:0] lv,
                       input logic en, input logic ar);
    if (rst) begin
      m_count = 0; m_reload = 0; m_state = 0; m_tc = 0;
    end else if (ld) begin
      m_count = lv; m_reload = lv; m_tc = 0;
      m_state = (lv != 0) ? 1 : 0;
    end else if (m_state == 1 && en) begin
      if (m_count > 1) begin
        m_count = m_count - 1; m_tc = 0;
      end else begin
        m_tc = 1;
        if (ar) m_count = m_reload;
        else begin m_count = 0; m_state = 2; end
      end
    end else begin
      m_tc = 0;
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic ld,
                      input logic [W-1:0] lv, input logic en, input logic ar);
    exp_t e;
    reset = rst; load = ld; load_value = lv; enable = en; auto_reload = ar;
    model(rst, ld, lv, en, ar);
    e.count = m_count;
    e.zero = (m_count == 0);
    e.tc = m_tc;
    e.running = (m_state == 1);
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    checks++;
    assert (count === e.count) else begin
      errors++; $error("FAIL %s count: got %0d expected %0d", tag, count, e.count);
    end
    checks++;
    assert (zero === e.zero) else begin
      errors++; $error("FAIL %s zero: got %0b expected %0b", tag, zero, e.zero);
    end
    checks++;
    assert (tc_pulse === e.tc) else begin
      errors++; $error("FAIL %s tc_pulse: got %0b expected %0b", tag, tc_pulse, e.tc);
    end
    checks++;
    assert (running === e.running) else begin
      errors++; $error("FAIL %s running: got %0b expected %0b", tag, running, e.running);
    end
  endtask

  int pulses;
  int last_pulse;
  int gap;

  initial begin
    // Reset held two cycles, then enable with no load.
    step("reset", 1, 0, 0, 0, 0);
    step("reset", 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("idle_en", 0, 0, 0, 1, 0);

    // One-shot from 3, then hold at zero for 10 cycles.
    step("os_load", 0, 1, 4'd3, 1, 0);
    for (int i = 0; i < 13; i++) step("oneshot", 0, 0, 0, 1, 0);

    // Periodic from 4 with an enable gap; also measure pulse spacing.
    step("ar_load", 0, 1, 4'd4, 1, 1);
    pulses = 0; last_pulse = -1; gap = 0;
    for (int i = 0; i < 16; i++) begin
      logic en_i;
      en_i = !(i == 5 || i == 6);
      step("autoreload", 0, 0, 0, en_i, 1);
      if (tc_pulse === 1'b1) begin
        if (last_pulse >= 0) gap = i - last_pulse;
        last_pulse = i;
        pulses++;
      end
    end
    // Pulses at i=3, 9 (stretched by 2), 13.
    checks++;
    assert (pulses == 3) else begin
      errors++; $error("FAIL ar_pulse_count: got %0d expected %0d", pulses, 3);
    end
    checks++;
    assert (gap == 4) else begin
      errors++; $error("FAIL ar_period: got %0d expected %0d", gap, 4);
    end

    // Load zero stays idle.
    step("load0", 0, 1, 4'd0, 1, 1);
    for (int i = 0; i < 3; i++) step("load0_hold", 0, 0, 0, 1, 1);

    // Full range: 15 enabled cycles to expiry.
    step("load15", 0, 1, 4'd15, 1, 0);
    for (int i = 0; i < 16; i++) step("full_range", 0, 0, 0, 1, 0);

    // Reload value 1 pulses every enabled cycle.
    step("load1", 0, 1, 4'd1, 1, 1);
    for (int i = 0; i < 4; i++) step("every_cycle", 0, 0, 0, 1, 1);

    // Load colliding with expiry: load wins, no pulse.
    step("col_load", 0, 1, 4'd3, 1, 1);
    step("col_run", 0, 0, 0, 1, 1);
    step("col_run", 0, 0, 0, 1, 1);
    step("col_load5", 0, 1, 4'd5, 1, 1);
    for (int i = 0; i < 3; i++) step("col_after", 0, 0, 0, 1, 1);

    // Reset mid-count at count 2.
    step("rst_load", 0, 1, 4'd4, 1, 0);
    step("rst_run", 0, 0, 0, 1, 0);
    step("rst_run", 0, 0, 0, 1, 0);
    step("rst_mid", 1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step("rst_after", 0, 0, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
